// File: rtl/dac_output_conditioner.sv
// rtl/dac_output_conditioner.sv - clamp, slew-limit and offset-binary convert a signed sample for a DAC
module dac_output_conditioner #(
  parameter logic [15:0] MIDSCALE = 16'h8000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        enable_in,
  input  logic [15:0] signal_in,
  input  logic        valid_in,
  input  logic [15:0] minval_in,
  input  logic [15:0] maxval_in,
  input  logic [15:0] slew_in,
  output logic [15:0] DAC_out,
  output logic        valid_out,
  output logic        sat_hi_out,
  output logic        sat_lo_out,
  output logic        slewing_out,
  output logic        busy_out
);

  typedef enum logic [1:0] {IDLE, TRACK, RAMP_DOWN} state_t;
  state_t state, state_next;

  logic               accept;
  logic signed [15:0] sig, mn, mx, clamp_val;
  logic               clamp_hi, clamp_lo;

  logic               s1_valid, s1_hi, s1_lo;
  logic signed [15:0] s1_val;

  logic               ramp_step, s2_in_valid, step_limited;
  logic signed [15:0] target, current, current_next;
  logic signed [16:0] diff, slew17;

  logic               s2_valid, s2_hi, s2_lo, s2_slewing;

  assign accept = (state == TRACK) && enable_in && valid_in;
  assign sig    = $signed(signal_in);
  assign mn     = $signed(minval_in);
  assign mx     = $signed(maxval_in);

  // Inverted limits pin the result to the lower limit; flags still report each limit on its own.
  always_comb begin
    clamp_hi  = sig > mx;
    clamp_lo  = sig < mn;
    clamp_val = sig;
    if (mn > mx)     clamp_val = mn;
    else if (clamp_lo) clamp_val = mn;
    else if (clamp_hi) clamp_val = mx;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_valid <= 1'b0;
      s1_val   <= '0;
      s1_hi    <= 1'b0;
      s1_lo    <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_val <= clamp_val;
        s1_hi  <= clamp_hi;
        s1_lo  <= clamp_lo;
      end
    end
  end

  // Ramp-down steps toward 0 only when no tracked sample is in flight and current is non-zero.
  assign ramp_step   = (state == RAMP_DOWN) && !s1_valid && (current != '0);
  assign s2_in_valid = s1_valid || ramp_step;
  assign target      = s1_valid ? s1_val : '0;
  assign diff        = {target[15], target} - {current[15], current};
  assign slew17      = $signed({1'b0, slew_in});

  always_comb begin
    current_next = target;
    step_limited = 1'b0;
    if (slew_in != '0) begin
      if (diff > slew17) begin
        current_next = current + $signed(slew_in);
        step_limited = 1'b1;
      end else if (diff < -slew17) begin
        current_next = current - $signed(slew_in);
        step_limited = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      current    <= '0;
      s2_valid   <= 1'b0;
      s2_hi      <= 1'b0;
      s2_lo      <= 1'b0;
      s2_slewing <= 1'b0;
    end else begin
      s2_valid <= s2_in_valid;
      if (s2_in_valid) begin
        current    <= current_next;
        s2_hi      <= s1_valid && s1_hi;
        s2_lo      <= s1_valid && s1_lo;
        s2_slewing <= step_limited;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      DAC_out     <= MIDSCALE;
      valid_out   <= 1'b0;
      sat_hi_out  <= 1'b0;
      sat_lo_out  <= 1'b0;
      slewing_out <= 1'b0;
    end else begin
      valid_out   <= s2_valid;
      sat_hi_out  <= s2_valid && s2_hi;
      sat_lo_out  <= s2_valid && s2_lo;
      slewing_out <= s2_valid && s2_slewing;
      if (s2_valid) DAC_out <= (current ^ 16'h8000) + (MIDSCALE - 16'h8000);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  // Leave RAMP_DOWN only once current is 0 and the last step has drained out of the pipeline.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (enable_in) state_next = TRACK;
      TRACK:     if (!enable_in) state_next = RAMP_DOWN;
      RAMP_DOWN: begin
        if (enable_in) state_next = TRACK;
        else if ((current == '0) && !s1_valid && !s2_valid) state_next = IDLE;
      end
      default:   state_next = IDLE;
    endcase
  end

  assign busy_out = (state != IDLE);

endmodule

// File: tb/tb_dac_output_conditioner.sv
// tb/tb_dac_output_conditioner.sv - scoreboard bench for dac_output_conditioner with directed vectors
module tb_dac_output_conditioner;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        enable_in;
  logic [15:0] signal_in;
  logic        valid_in;
  logic [15:0] minval_in;
  logic [15:0] maxval_in;
  logic [15:0] slew_in;
  logic [15:0] DAC_out;
  logic        valid_out;
  logic        sat_hi_out;
  logic        sat_lo_out;
  logic        slewing_out;
  logic        busy_out;

  typedef struct {
    logic [15:0] dac;
    logic        hi;
    logic        lo;
    logic        slw;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cycle = 0;

  dac_output_conditioner #(.MIDSCALE(16'h8000)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .enable_in   (enable_in),
    .signal_in   (signal_in),
    .valid_in    (valid_in),
    .minval_in   (minval_in),
    .maxval_in   (maxval_in),
    .slew_in     (slew_in),
    .DAC_out     (DAC_out),
    .valid_out   (valid_out),
    .sat_hi_out  (sat_hi_out),
    .sat_lo_out  (sat_lo_out),
    .slewing_out (slewing_out),
    .busy_out    (busy_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk_in) begin
    #1;
    if (valid_out === 1'b1) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid_out: DAC_out %0h with nothing expected (t=%0t)", DAC_out, $time);
      end else begin
        e = q.pop_front();
        check("dac_out", DAC_out, e.dac);
        check("sat_hi", sat_hi_out, e.hi);
        check("sat_lo", sat_lo_out, e.lo);
        check("slewing", slewing_out, e.slw);
        if (e.cyc >= 0) check("latency_cycle", cycle, e.cyc);
      end
    end
  end

  task automatic sample(input logic [15:0] v, input logic [15:0] dac,
                        input logic hi, input logic lo, input logic slw);
    valid_in  = 1'b1;
    signal_in = v;
    q.push_back('{dac, hi, lo, slw, cycle + 3});
    @(negedge clk_in);
  endtask

  task automatic push_ramp(input logic [15:0] dac, input logic slw);
    q.push_back('{dac, 1'b0, 1'b0, slw, -1});
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) @(negedge clk_in);
  endtask

  task automatic wait_not_busy(input string name);
    for (int i = 0; i < 30; i++) begin
      if (!busy_out) break;
      @(negedge clk_in);
    end
    check(name, busy_out, 1'b0);
  endtask

  initial begin
    rst_in    = 1'b1;
    enable_in = 1'b0;
    signal_in = '0;
    valid_in  = 1'b0;
    minval_in = 16'h8001;
    maxval_in = 16'h7FFF;
    slew_in   = '0;
    repeat (3) @(negedge clk_in);
    check("rst_dac", DAC_out, 16'h8000);
    check("rst_valid", valid_out, 1'b0);
    check("rst_busy", busy_out, 1'b0);
    check("rst_flags", {sat_hi_out, sat_lo_out, slewing_out}, 3'b000);
    rst_in = 1'b0;
    @(negedge clk_in);

    // Plain pass-through, then upper, lower and inverted clamps with slew disabled.
    enable_in = 1'b1;
    @(negedge clk_in);
    check("busy_track", busy_out, 1'b1);
    sample(16'd1000, 16'h83E8, 1'b0, 1'b0, 1'b0);
    idle(5);
    maxval_in = 16'd100;
    sample(16'd500, 16'h8064, 1'b1, 1'b0, 1'b0);
    maxval_in = 16'h7FFF;
    minval_in = -16'sd100;
    sample(-16'sd500, 16'h7F9C, 1'b0, 1'b1, 1'b0);
    minval_in = 16'd50;
    maxval_in = -16'sd50;
    sample(16'd0, 16'h8032, 1'b1, 1'b1, 1'b0);
    idle(5);

    // Ramp 50 -> 0 in one step, back to IDLE, then slew-limited ramp-in from 0.
    minval_in = 16'h8001;
    maxval_in = 16'h7FFF;
    push_ramp(16'h8000, 1'b0);
    enable_in = 1'b0;
    wait_not_busy("busy_idle_1");
    idle(3);
    slew_in   = 16'd256;
    enable_in = 1'b1;
    @(negedge clk_in);
    sample(16'd1024, 16'h8100, 1'b0, 1'b0, 1'b1);
    sample(16'd1024, 16'h8200, 1'b0, 1'b0, 1'b1);
    sample(16'd1024, 16'h8300, 1'b0, 1'b0, 1'b1);
    sample(16'd1024, 16'h8400, 1'b0, 1'b0, 1'b0);
    sample(16'd1024, 16'h8400, 1'b0, 1'b0, 1'b0);
    sample(16'd1024, 16'h8400, 1'b0, 1'b0, 1'b0);
    idle(5);

    // Ramp-down 1024 -> 512 -> 0 with slew 512.
    slew_in = 16'd512;
    push_ramp(16'h8200, 1'b1);
    push_ramp(16'h8000, 1'b0);
    enable_in = 1'b0;
    wait_not_busy("busy_idle_2");
    check("queue_drained_ramp", q.size(), 0);

    // One-cycle enable drop with a coincident sample: sample discarded, one step, resume from 768.
    slew_in   = 16'd0;
    enable_in = 1'b1;
    @(negedge clk_in);
    sample(16'd1024, 16'h8400, 1'b0, 1'b0, 1'b0);
    idle(5);
    slew_in   = 16'd256;
    enable_in = 1'b0;
    valid_in  = 1'b1;
    signal_in = -16'sd1000;
    push_ramp(16'h8300, 1'b1);
    @(negedge clk_in);
    enable_in = 1'b1;
    valid_in  = 1'b0;
    @(negedge clk_in);
    check("busy_resume", busy_out, 1'b1);
    sample(16'd1024, 16'h8400, 1'b0, 1'b0, 1'b0);
    idle(5);

    // Asynchronous reset in the middle of a slow ramp.
    slew_in = 16'd1;
    push_ramp(16'h83FF, 1'b1);
    push_ramp(16'h83FE, 1'b1);
    enable_in = 1'b0;
    repeat (4) @(posedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    check("async_rst_dac", DAC_out, 16'h8000);
    check("async_rst_busy", busy_out, 1'b0);
    check("async_rst_valid", valid_out, 1'b0);
    repeat (2) @(negedge clk_in);
    check("rst_hold_dac", DAC_out, 16'h8000);
    rst_in = 1'b0;
    repeat (4) @(negedge clk_in);
    check("queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
